// File: rtl/memory_stage.sv
// Y86-64 memory stage: data-memory access, memory status and the M->W pipeline register.
// Accesses can take MEM_LAT extra cycles; m_busy tells the hazard unit to hold M_* steady.
//
//  state | meaning
//  IDLE  | accepting a new M_* instruction; single-cycle ops complete here
//  WAIT  | multi-cycle access in flight, cnt counts the remaining wait cycles
module memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int MEM_LAT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valA,
    input  logic [63:0] M_valE,
    input  logic        W_stall,
    output logic [1:0]  m_stat,
    output logic [63:0] m_valM,
    output logic        m_busy,
    output logic [1:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam bit LAT_EN = (MEM_LAT > 0);
    localparam logic [63:0]   MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    localparam logic [1:0] STAT_AOK  = 2'b01;
    localparam logic [1:0] STAT_ADR  = 2'b11;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [7:0]    mem [MEM_BYTES];
    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic          acc_en;
    logic          is_write;
    logic [63:0]   addr;
    logic          addr_ok;
    logic          acc_ok;
    logic [AW-1:0] idx;
    logic [63:0]   rd_word;
    logic          done;
    logic          we;

    logic unused_cnd;
    assign unused_cnd = M_cnd;

    always_comb begin
        acc_en   = 1'b0;
        is_write = 1'b0;
        addr     = M_valE;
        case (M_icode)
            4'h4, 4'h8, 4'hA: begin
                acc_en   = 1'b1;
                is_write = 1'b1;
            end
            4'h5: acc_en = 1'b1;
            4'h9, 4'hB: begin
                acc_en = 1'b1;
                addr   = M_valA;
            end
            default: acc_en = 1'b0;
        endcase
    end

    // Full 64-bit unsigned compare, so addresses near 2^64 cannot wrap into range.
    assign addr_ok = (addr <= MAX_ADDR);
    assign acc_ok  = acc_en && addr_ok;
    assign idx     = addr_ok ? addr[AW-1:0] : '0;
    assign m_stat  = (acc_en && !addr_ok) ? STAT_ADR : M_stat;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 8; k++) begin
            rd_word[8*k +: 8] = mem[idx + AW'(k)];
        end
    end

    assign m_valM = (acc_ok && !is_write && (M_stat == STAT_AOK)) ? rd_word : 64'd0;

    // done marks the cycle in which the access (if any) finishes and W takes the result.
    assign done   = (state == IDLE) ? !(acc_ok && LAT_EN) : (cnt == '0);
    assign m_busy = !reset && !done;
    assign we     = is_write && acc_ok && (M_stat == STAT_AOK) && !W_stall && !reset && done;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                mem[idx + AW'(k)] <= M_valA[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            W_stat  <= STAT_AOK;
            W_icode <= ICODE_NOP;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
            W_valE  <= 64'd0;
            W_valM  <= 64'd0;
        end else if (!W_stall) begin
            case (state)
                IDLE: begin
                    if (!done) begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase

            if (done) begin
                W_stat  <= m_stat;
                W_icode <= M_icode;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
                W_valE  <= M_valE;
                W_valM  <= m_valM;
            end else begin
                W_stat  <= STAT_AOK;
                W_icode <= ICODE_NOP;
                W_dstE  <= REG_NONE;
                W_dstM  <= REG_NONE;
                W_valE  <= 64'd0;
                W_valM  <= 64'd0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: one instance single-cycle, one with three wait cycles.
// Stimulus pushes expected W contents; a monitor per instance pops them when W loads a result.
module tb_memory_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic [1:0]  mstat   [2];
    logic [3:0]  micode  [2];
    logic        mcnd    [2];
    logic [3:0]  mdste   [2];
    logic [3:0]  mdstm   [2];
    logic [63:0] mvala   [2];
    logic [63:0] mvale   [2];
    logic        wstall  [2];
    logic [1:0]  o_mstat [2];
    logic [63:0] o_mvalm [2];
    logic        busy    [2];
    logic [1:0]  w_stat  [2];
    logic [3:0]  w_icode [2];
    logic [3:0]  w_dste  [2];
    logic [3:0]  w_dstm  [2];
    logic [63:0] w_vale  [2];
    logic [63:0] w_valm  [2];

    memory_stage #(.MEM_BYTES(1024), .MEM_LAT(0)) dut0 (
        .clk(clk), .reset(rst[0]), .M_stat(mstat[0]), .M_icode(micode[0]), .M_cnd(mcnd[0]),
        .M_dstE(mdste[0]), .M_dstM(mdstm[0]), .M_valA(mvala[0]), .M_valE(mvale[0]),
        .W_stall(wstall[0]), .m_stat(o_mstat[0]), .m_valM(o_mvalm[0]), .m_busy(busy[0]),
        .W_stat(w_stat[0]), .W_icode(w_icode[0]), .W_dstE(w_dste[0]), .W_dstM(w_dstm[0]),
        .W_valE(w_vale[0]), .W_valM(w_valm[0])
    );

    memory_stage #(.MEM_BYTES(1024), .MEM_LAT(3)) dut1 (
        .clk(clk), .reset(rst[1]), .M_stat(mstat[1]), .M_icode(micode[1]), .M_cnd(mcnd[1]),
        .M_dstE(mdste[1]), .M_dstM(mdstm[1]), .M_valA(mvala[1]), .M_valE(mvale[1]),
        .W_stall(wstall[1]), .m_stat(o_mstat[1]), .m_valM(o_mvalm[1]), .m_busy(busy[1]),
        .W_stat(w_stat[1]), .W_icode(w_icode[1]), .W_dstE(w_dste[1]), .W_dstM(w_dstm[1]),
        .W_valE(w_vale[1]), .W_valM(w_valm[1])
    );

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] valm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy0_seen = 1'b0;

    localparam logic [63:0] PAT  = 64'h1122334455667788;
    localparam logic [63:0] PATS = 64'h0011223344556677;
    localparam logic [63:0] V3F8 = 64'hA5A55A5A0F0FF0F0;
    localparam logic [63:0] V30  = 64'hCAFEF00D12345678;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int d);
        mstat[d]  = 2'b01;
        micode[d] = 4'h1;
        mcnd[d]   = 1'b0;
        mdste[d]  = 4'hF;
        mdstm[d]  = 4'hF;
        mvala[d]  = 64'd0;
        mvale[d]  = 64'd0;
        wstall[d] = 1'b0;
    endtask

    task automatic mon(input int d);
        bit   f;
        exp_t e;
        forever begin
            @(negedge clk);
            f = !rst[d] && !wstall[d] && !busy[d] && (micode[d] != 4'h1);
            @(posedge clk);
            #1;
            if (f) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_w dut%0d: got icode %h, expected no result", d, w_icode[d]);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("w_stat dut%0d", d), 64'(w_stat[d]), 64'(e.stat));
                    chk($sformatf("w_icode dut%0d", d), 64'(w_icode[d]), 64'(e.icode));
                    chk($sformatf("w_dste dut%0d", d), 64'(w_dste[d]), 64'(e.dste));
                    chk($sformatf("w_dstm dut%0d", d), 64'(w_dstm[d]), 64'(e.dstm));
                    chk($sformatf("w_vale dut%0d", d), w_vale[d], e.vale);
                    chk($sformatf("w_valm dut%0d", d), w_valm[d], e.valm);
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    always @(negedge clk) if (busy[0]) busy0_seen = 1'b1;

    // Called at posedge+2. Holds the instruction until the DUT accepts it, optionally
    // raising W_stall for cycles s_at .. s_at+s_len-1 (cycle 0 is the first presentation).
    task automatic issue(input int d, input logic [1:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] va, input logic [63:0] ve,
                         input logic [1:0] x_stat, input logic [63:0] x_valm,
                         input int x_lat, input int s_at, input int s_len);
        exp_t e;
        int   n;
        bit   fired;
        bit   f;
        bit   stl;
        mstat[d]  = st;
        micode[d] = ic;
        mdste[d]  = de;
        mdstm[d]  = dm;
        mvala[d]  = va;
        mvale[d]  = ve;
        wstall[d] = 1'b0;
        e.stat  = x_stat;
        e.icode = ic;
        e.dste  = de;
        e.dstm  = dm;
        e.vale  = ve;
        e.valm  = x_valm;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        #1;
        chk($sformatf("m_stat dut%0d ic%h @%h", d, ic, ve), 64'(o_mstat[d]), 64'(x_stat));
        chk($sformatf("m_valM dut%0d ic%h @%h", d, ic, ve), o_mvalm[d], x_valm);
        n = 0;
        fired = 1'b0;
        while (!fired && n < 50) begin
            @(negedge clk);
            f   = !wstall[d] && !busy[d];
            stl = wstall[d];
            @(posedge clk);
            #1;
            n++;
            if (f) fired = 1'b1;
            else if (!stl) chk($sformatf("bubble dut%0d cyc%0d", d, n), 64'(w_icode[d]), 64'h1);
            #1;
            wstall[d] = (n >= s_at) && (n < s_at + s_len);
        end
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d ic%h: got no completion in %0d cycles, expected %0d", d, ic, n, x_lat);
        end else begin
            chk($sformatf("latency dut%0d ic%h", d, ic), 64'(n), 64'(x_lat));
        end
        idle(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by %0t, expected earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            idle(d);
            rst[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset w_icode dut%0d", d), 64'(w_icode[d]), 64'h1);
            chk($sformatf("reset w_stat dut%0d", d), 64'(w_stat[d]), 64'h1);
            chk($sformatf("reset w_dste dut%0d", d), 64'(w_dste[d]), 64'hF);
            chk($sformatf("reset w_dstm dut%0d", d), 64'(w_dstm[d]), 64'hF);
            chk($sformatf("reset w_valm dut%0d", d), w_valm[d], 64'd0);
            chk($sformatf("reset busy dut%0d", d), 64'(busy[d]), 64'd0);
        end
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single-cycle instance
        issue(0, 2'b01, 4'h4, 4'hF, 4'hF, 64'd0, 64'h18, 2'b01, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h4, 4'hF, 4'hF, PAT, 64'h10, 2'b01, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h5, 4'hF, 4'h3, 64'd0, 64'h10, 2'b01, PAT, 1, 0, 0);
        issue(0, 2'b01, 4'hB, 4'h4, 4'h4, 64'h10, 64'h18, 2'b01, PAT, 1, 0, 0);
        issue(0, 2'b01, 4'h5, 4'hF, 4'h5, 64'd0, 64'h11, 2'b01, PATS, 1, 0, 0);
        issue(0, 2'b01, 4'h4, 4'hF, 4'hF, V3F8, 64'h3F8, 2'b01, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h5, 4'hF, 4'h6, 64'd0, 64'h3F9, 2'b11, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h4, 4'hF, 4'hF, 64'hFFFFFFFFFFFFFFFF, 64'h3F9, 2'b11, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h5, 4'hF, 4'h6, 64'd0, 64'h3F8, 2'b01, V3F8, 1, 0, 0);
        issue(0, 2'b01, 4'h5, 4'hF, 4'h6, 64'd0, 64'hFFFFFFFFFFFFFFFC, 2'b11, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h4, 4'hF, 4'hF, 64'h77, 64'h20, 2'b01, 64'd0, 1, 0, 0);
        issue(0, 2'b10, 4'h4, 4'hF, 4'hF, 64'h5, 64'h20, 2'b10, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h5, 4'hF, 4'h7, 64'd0, 64'h20, 2'b01, 64'h77, 1, 0, 0);
        issue(0, 2'b01, 4'h6, 4'h2, 4'hF, 64'd0, 64'd123, 2'b01, 64'd0, 1, 0, 0);
        issue(0, 2'b01, 4'h9, 4'hF, 4'hF, 64'h10, 64'h18, 2'b01, PAT, 1, 0, 0);
        issue(0, 2'b10, 4'h5, 4'hF, 4'h3, 64'd0, 64'h10, 2'b10, 64'd0, 1, 0, 0);

        // Three-wait-cycle instance
        issue(1, 2'b01, 4'h4, 4'hF, 4'hF, PAT, 64'h10, 2'b01, 64'd0, 4, 0, 0);
        issue(1, 2'b01, 4'h5, 4'hF, 4'h3, 64'd0, 64'h10, 2'b01, PAT, 4, 0, 0);
        issue(1, 2'b01, 4'h5, 4'hF, 4'h3, 64'd0, 64'h10, 2'b01, PAT, 6, 1, 2);
        issue(1, 2'b01, 4'h6, 4'h2, 4'hF, 64'd0, 64'd55, 2'b01, 64'd0, 1, 0, 0);
        issue(1, 2'b01, 4'h5, 4'hF, 4'h3, 64'd0, 64'h3F9, 2'b11, 64'd0, 1, 0, 0);
        issue(1, 2'b01, 4'h4, 4'hF, 4'hF, V30, 64'h30, 2'b01, 64'd0, 4, 0, 0);

        // Write abandoned by reset in its second wait cycle
        micode[1] = 4'h4;
        mvale[1]  = 64'h30;
        mvala[1]  = 64'hDEADBEEFDEADBEEF;
        mdste[1]  = 4'h2;
        repeat (2) @(posedge clk);
        #2;
        rst[1] = 1'b1;
        idle(1);
        @(posedge clk);
        #1;
        chk("abort busy dut1", 64'(busy[1]), 64'd0);
        chk("abort w_icode dut1", 64'(w_icode[1]), 64'h1);
        chk("abort w_dste dut1", 64'(w_dste[1]), 64'hF);
        chk("abort w_stat dut1", 64'(w_stat[1]), 64'h1);
        #1;
        rst[1] = 1'b0;
        issue(1, 2'b01, 4'h5, 4'hF, 4'h3, 64'd0, 64'h30, 2'b01, V30, 4, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard q0 drained", 64'(q0.size()), 64'd0);
        chk("scoreboard q1 drained", 64'(q1.size()), 64'd0);
        chk("busy never high dut0", 64'(busy0_seen), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
